// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: exhaustive patterns per fault, golden compare.
// Optional FAULT_DROP_EN: stop applying patterns to a fault once it is detected.
module fault_campaign_ctrl #(
  parameter int PAT_W   = 1,
  parameter int OUT_W   = 1,
  parameter int NUM_FLT = 4,
  parameter int SETTLE  = 1,
  localparam int IW = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1,
  localparam int CW = $clog2(NUM_FLT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [OUT_W-1:0]   resp,
  input  logic [OUT_W-1:0]   gold,
  output logic [PAT_W-1:0]   pat_out,
  output logic               flt_en,
  output logic [IW-1:0]      flt_idx,
  output logic               busy,
  output logic               done,
  output logic [NUM_FLT-1:0] det_vec,
  output logic [CW-1:0]      det_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APPLY  = 3'd1;
  localparam logic [2:0] SETTL  = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SLAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IW-1:0] FLAST = IW'(NUM_FLT - 1);

  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic          new_det;
  logic          last_pat;
  logic          last_flt;
  logic          skip;

  assign new_det  = (resp != gold) && !det_vec[flt_idx];
  assign last_pat = &pat_out;
  assign last_flt = (flt_idx == FLAST);

`ifdef FAULT_DROP_EN
  assign skip = new_det;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      scnt    <= '0;
      pat_out <= '0;
      flt_en  <= 1'b0;
      flt_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      det_vec <= '0;
      det_cnt <= '0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start && !abort) begin
        det_vec <= '0;
        det_cnt <= '0;
        flt_idx <= '0;
        pat_out <= '0;
        flt_en  <= 1'b1;
        busy    <= 1'b1;
        state   <= APPLY;
      end
    end else if (abort) begin
      state  <= IDLE;
      busy   <= 1'b0;
      flt_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        APPLY: begin
          scnt  <= '0;
          state <= (SETTLE == 0) ? CHECK : SETTL;
        end
        SETTL: begin
          scnt <= scnt + SW'(1);
          if (scnt == SLAST) state <= CHECK;
        end
        CHECK: begin
          if (new_det) begin
            det_vec[flt_idx] <= 1'b1;
            det_cnt <= det_cnt + CW'(1);
          end
          if (!last_pat && !skip) begin
            pat_out <= pat_out + PAT_W'(1);
            state   <= APPLY;
          end else if (last_flt) begin
            busy   <= 1'b0;
            flt_en <= 1'b0;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            pat_out <= '0;
            flt_idx <= flt_idx + IW'(1);
            state   <= APPLY;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl driving an inverter with stuck-at injection.
// Expected results are queued per run and checked by a monitor on done / pattern change.
module tb_fault_campaign_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [0:0] resp, gold;
  logic [0:0] pat_out;
  logic       flt_en;
  logic [1:0] flt_idx;
  logic       busy, done;
  logic [3:0] det_vec;
  logic [2:0] det_cnt;
  logic       mask2 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int ndone = 0;

  typedef struct {
    logic [3:0] vec;
    logic [2:0] cnt;
    int         cyc;
  } res_t;

  res_t exp_q[$];
  int   seq_q[$];

  fault_campaign_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .resp(resp), .gold(gold), .pat_out(pat_out), .flt_en(flt_en),
    .flt_idx(flt_idx), .busy(busy), .done(done),
    .det_vec(det_vec), .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  // Faulty inverter: idx[1]=0 forces the input, idx[1]=1 forces the output
  logic pin, fout;
  always_comb begin
    pin  = pat_out[0];
    if (flt_en && !flt_idx[1]) pin = flt_idx[0];
    fout = ~pin;
    if (flt_en && flt_idx[1]) fout = flt_idx[0];
    gold = ~pat_out;
    resp = (mask2 && flt_en && flt_idx == 2'd2) ? gold : fout;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: applied (idx,pat) pairs and end-of-campaign results
  logic pbusy = 1'b0;
  int   ppair = 0;
  int   bcnt = 0;
  always @(negedge clk) begin
    int pair;
    pair = {flt_idx, pat_out};
    if (busy) begin
      bcnt = pbusy ? bcnt + 1 : 1;
      if (!pbusy || pair != ppair) begin
        if (seq_q.size() == 0) chk("seq_extra", pair, -1);
        else chk("seq_pair", pair, seq_q.pop_front());
      end
    end
    if (done) begin
      ndone++;
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        res_t e;
        e = exp_q.pop_front();
        chk("det_vec", det_vec, e.vec);
        chk("det_cnt", det_cnt, e.cnt);
        chk("busy_cycles", bcnt, e.cyc);
        chk("flt_en_done", flt_en, 0);
      end
    end
    pbusy = busy;
    ppair = pair;
  end

  task automatic push_run(input logic [3:0] v, input logic [2:0] c,
                          input int cyc, input int s[8], input int n);
    res_t r;
    r.vec = v; r.cnt = c; r.cyc = cyc;
    if (cyc > 0) exp_q.push_back(r);
    for (int i = 0; i < n; i++) seq_q.push_back(s[i]);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 80) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pat"}, pat_out, 0);
    chk({nm, "_flt_en"}, flt_en, 0);
    chk({nm, "_idx"}, flt_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_vec"}, det_vec, 0);
    chk({nm, "_cnt"}, det_cnt, 0);
  endtask

  int full_s[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`ifdef FAULT_DROP_EN
  int run_s[8]  = '{0, 1, 2, 4, 6, 7, 0, 0};
  int m2_s[8]   = '{0, 1, 2, 4, 5, 6, 7, 0};
  int ab_s[8]   = '{0, 1, 2, 4, 0, 0, 0, 0};
  localparam int RUN_N = 6, RUN_C = 18, M2_N = 7, M2_C = 21;
`else
  int run_s[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
  int m2_s[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int ab_s[8]   = '{0, 1, 2, 3, 0, 0, 0, 0};
  localparam int RUN_N = 8, RUN_C = 24, M2_N = 8, M2_C = 24;
`endif

  initial begin
    int nd;
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // start+abort together in IDLE: stays idle
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_busy", busy, 0);
    chk("start_abort_en", flt_en, 0);

    // clean campaign, with a stray start while busy
    push_run(4'b1111, 3'd4, RUN_C, run_s, RUN_N);
    do_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();

    // fault 2 made undetectable
    mask2 = 1'b1;
    push_run(4'b1011, 3'd3, M2_C, m2_s, M2_N);
    do_start();
    wait_done();
    mask2 = 1'b0;

    // abort at busy cycle 10
    nd = ndone;
    push_run(4'b0, 3'd0, 0, ab_s, 4);
    do_start();
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_flt_en", flt_en, 0);
    chk("abort_vec", det_vec, 4'b0011);
    chk("abort_cnt", det_cnt, 2);
    repeat (3) @(negedge clk);
    chk("abort_no_done", ndone, nd);

    push_run(4'b1111, 3'd4, RUN_C, run_s, RUN_N);
    do_start();
    wait_done();

    // reset during SETTLE of fault 1
    nd = ndone;
    push_run(4'b0, 3'd0, 0, full_s, 3);
    do_start();
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_done", ndone, nd);

    push_run(4'b1111, 3'd4, RUN_C, run_s, RUN_N);
    do_start();
    wait_done();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("seq_q_empty", seq_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
